// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with mult/div sequencing; decode latency 1 cycle.
// Backpressure: InReady drops from an md accept until the MdDone cycle ends.
module alu_ctrl_seq #(
  parameter int OP_W      = 4,
  parameter int FUNCT_W   = 6,
  parameter int CTRL_W    = 4,
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               InValid,
  output logic               InReady,
  input  logic [OP_W-1:0]    ALUOpSignal,
  input  logic [FUNCT_W-1:0] InstFunct,
  output logic               OutValid,
  output logic [CTRL_W-1:0]  ALUControlBit,
  output logic               IllegalOp,
  output logic               MdStart,
  output logic               MdBusy,
  output logic               MdDone,
  output logic               HiLoWrite
);

  if (CTRL_W < 4) begin : gBadCtrlW
    $error("alu_ctrl_seq: CTRL_W must be at least 4");
  end
  if ((MD_CYCLES - 1) >= (2 ** CNT_W) || MD_CYCLES < 1) begin : gBadMdCycles
    $error("alu_ctrl_seq: MD_CYCLES-1 does not fit in CNT_W bits");
  end

  localparam logic [CTRL_W-1:0] CodeAnd  = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] CodeOr   = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] CodeAdd  = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] CodeNor  = CTRL_W'(4'b0011);
  localparam logic [CTRL_W-1:0] CodeSll  = CTRL_W'(4'b0100);
  localparam logic [CTRL_W-1:0] CodeSrl  = CTRL_W'(4'b0101);
  localparam logic [CTRL_W-1:0] CodeSub  = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] CodeSlt  = CTRL_W'(4'b0111);
  localparam logic [CTRL_W-1:0] CodeXor  = CTRL_W'(4'b1000);
  localparam logic [CTRL_W-1:0] CodeSltu = CTRL_W'(4'b1001);
  localparam logic [CTRL_W-1:0] CodeSra  = CTRL_W'(4'b1010);
  localparam logic [CTRL_W-1:0] CodeNop  = CTRL_W'(4'b1111);

  localparam logic [OP_W-1:0] OpMem   = OP_W'(4'b0000);
  localparam logic [OP_W-1:0] OpBr    = OP_W'(4'b0001);
  localparam logic [OP_W-1:0] OpRType = OP_W'(4'b0010);
  localparam logic [OP_W-1:0] OpAddi  = OP_W'(4'b0011);
  localparam logic [OP_W-1:0] OpAndi  = OP_W'(4'b0100);
  localparam logic [OP_W-1:0] OpOri   = OP_W'(4'b0101);
  localparam logic [OP_W-1:0] OpSlti  = OP_W'(4'b0110);
  localparam logic [OP_W-1:0] OpSltiu = OP_W'(4'b0111);
  localparam logic [OP_W-1:0] OpXori  = OP_W'(4'b1000);

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, nextState;
  logic [CNT_W-1:0]  cnt, nextCnt;
  logic [CTRL_W-1:0] decCode;
  logic              decIllegal;
  logic              decMd;
  logic              accept;

  always_comb begin
    decCode    = CodeNop;
    decIllegal = 1'b0;
    decMd      = 1'b0;
    case (ALUOpSignal)
      OpMem:   decCode = CodeAdd;
      OpBr:    decCode = CodeSub;
      OpAddi:  decCode = CodeAdd;
      OpAndi:  decCode = CodeAnd;
      OpOri:   decCode = CodeOr;
      OpSlti:  decCode = CodeSlt;
      OpSltiu: decCode = CodeSltu;
      OpXori:  decCode = CodeXor;
      OpRType: begin
        case (InstFunct)
          FUNCT_W'(6'b100100): decCode = CodeAnd;
          FUNCT_W'(6'b100101): decCode = CodeOr;
          FUNCT_W'(6'b100000),
          FUNCT_W'(6'b100001): decCode = CodeAdd;
          FUNCT_W'(6'b100111): decCode = CodeNor;
          FUNCT_W'(6'b100110): decCode = CodeXor;
          FUNCT_W'(6'b000000): decCode = CodeSll;
          FUNCT_W'(6'b000010): decCode = CodeSrl;
          FUNCT_W'(6'b000011): decCode = CodeSra;
          FUNCT_W'(6'b100010),
          FUNCT_W'(6'b100011): decCode = CodeSub;
          FUNCT_W'(6'b101010): decCode = CodeSlt;
          FUNCT_W'(6'b101011): decCode = CodeSltu;
          // mult/multu/div/divu: ALU idles with NOP while the md unit runs
          FUNCT_W'(6'b011000),
          FUNCT_W'(6'b011001),
          FUNCT_W'(6'b011010),
          FUNCT_W'(6'b011011): decMd = 1'b1;
          default:             decIllegal = 1'b1;
        endcase
      end
      default: decIllegal = 1'b1;
    endcase
  end

  assign InReady = rst_n && (state == IDLE);
  assign accept  = InValid && InReady;

  // The MdStart cycle is spent in BUSY with the counter frozen, so MdBusy
  // covers exactly MD_CYCLES cycles and MdDone lands MD_CYCLES+1 after accept.
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    case (state)
      IDLE: begin
        if (accept && decMd) begin
          nextState = BUSY;
          nextCnt   = CntLoad;
        end
      end
      BUSY: begin
        if (!MdStart) begin
          if (cnt == '0) begin
            nextState = DONE;
          end else begin
            nextCnt = cnt - 1'b1;
          end
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OutValid      <= 1'b0;
      ALUControlBit <= CodeNop;
      IllegalOp     <= 1'b0;
      MdStart       <= 1'b0;
    end else begin
      OutValid <= accept;
      MdStart  <= accept && decMd;
      if (accept) begin
        ALUControlBit <= decCode;
        IllegalOp     <= decIllegal;
      end
    end
  end

  assign MdBusy    = (state == BUSY) && !MdStart;
  assign MdDone    = (state == DONE);
  assign HiLoWrite = MdDone;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq with MD_CYCLES=4; inputs driven and outputs sampled on negedge.
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       InValid;
  logic       InReady;
  logic [3:0] ALUOpSignal;
  logic [5:0] InstFunct;
  logic       OutValid;
  logic [3:0] ALUControlBit;
  logic       IllegalOp;
  logic       MdStart;
  logic       MdBusy;
  logic       MdDone;
  logic       HiLoWrite;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq #(
    .OP_W(4), .FUNCT_W(6), .CTRL_W(4), .MD_CYCLES(4), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .InValid(InValid),
    .InReady(InReady),
    .ALUOpSignal(ALUOpSignal),
    .InstFunct(InstFunct),
    .OutValid(OutValid),
    .ALUControlBit(ALUControlBit),
    .IllegalOp(IllegalOp),
    .MdStart(MdStart),
    .MdBusy(MdBusy),
    .MdDone(MdDone),
    .HiLoWrite(HiLoWrite)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Present one input vector and advance to the next negedge.
  task automatic drive(input logic v, input logic [3:0] op, input logic [5:0] fn);
    InValid     = v;
    ALUOpSignal = op;
    InstFunct   = fn;
    @(negedge clk);
  endtask

  logic [3:0] tblOp   [4] = '{4'h2, 4'h2, 4'h4, 4'h7};
  logic [5:0] tblFn   [4] = '{6'h03, 6'h27, 6'h00, 6'h00};
  logic [3:0] tblCode [4] = '{4'hA, 4'h3, 4'h0, 4'h9};

  initial begin
    logic sawDone;
    rst_n = 1'b0;
    InValid = 1'b0;
    ALUOpSignal = '0;
    InstFunct = '0;
    repeat (2) @(negedge clk);

    checkVal("rst_outvalid", OutValid, 0);
    checkVal("rst_code", ALUControlBit, 4'hF);
    checkVal("rst_illegal", IllegalOp, 0);
    checkVal("rst_mdstart", MdStart, 0);
    checkVal("rst_mdbusy", MdBusy, 0);
    checkVal("rst_mddone", MdDone, 0);
    checkVal("rst_hilo", HiLoWrite, 0);
    checkVal("rst_inready", InReady, 0);

    rst_n = 1'b1;
    @(negedge clk);
    checkVal("rdy_after_rst", InReady, 1);
    checkVal("idle_outvalid", OutValid, 0);

    drive(1'b1, 4'h2, 6'h20);
    checkVal("add_valid", OutValid, 1);
    checkVal("add_code", ALUControlBit, 4'h2);
    checkVal("add_illegal", IllegalOp, 0);

    // Back-to-back: beq, sltu, xori
    checkVal("b2b_rdy0", InReady, 1);
    drive(1'b1, 4'h1, 6'h00);
    checkVal("b2b_code0", ALUControlBit, 4'h6);
    checkVal("b2b_valid0", OutValid, 1);
    checkVal("b2b_rdy1", InReady, 1);
    drive(1'b1, 4'h2, 6'h2B);
    checkVal("b2b_code1", ALUControlBit, 4'h9);
    checkVal("b2b_valid1", OutValid, 1);
    checkVal("b2b_rdy2", InReady, 1);
    drive(1'b1, 4'h8, 6'h00);
    checkVal("b2b_code2", ALUControlBit, 4'h8);
    checkVal("b2b_valid2", OutValid, 1);

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, tblOp[i], tblFn[i]);
      checkVal($sformatf("tbl_code%0d", i), ALUControlBit, tblCode[i]);
      checkVal($sformatf("tbl_illegal%0d", i), IllegalOp, 0);
    end

    drive(1'b1, 4'h2, 6'h3F);
    checkVal("badfn_code", ALUControlBit, 4'hF);
    checkVal("badfn_illegal", IllegalOp, 1);
    checkVal("badfn_mdstart", MdStart, 0);
    drive(1'b1, 4'hF, 6'h20);
    checkVal("badop_code", ALUControlBit, 4'hF);
    checkVal("badop_illegal", IllegalOp, 1);
    checkVal("badop_mdstart", MdStart, 0);
    drive(1'b1, 4'h0, 6'h00);
    checkVal("legal_clears_illegal", IllegalOp, 0);
    drive(1'b0, 4'h1, 6'h00);
    checkVal("noxfer_valid", OutValid, 0);
    checkVal("noxfer_hold", ALUControlBit, 4'h2);

    // mult with an add held on InValid throughout BUSY
    drive(1'b1, 4'h2, 6'h18);
    checkVal("mult_valid", OutValid, 1);
    checkVal("mult_code", ALUControlBit, 4'hF);
    checkVal("mult_illegal", IllegalOp, 0);
    checkVal("mult_start", MdStart, 1);
    checkVal("mult_busy1", MdBusy, 0);
    checkVal("mult_rdy1", InReady, 0);
    InValid = 1'b1;
    ALUOpSignal = 4'h0;
    InstFunct = 6'h00;
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      checkVal($sformatf("mult_start%0d", k), MdStart, 0);
      checkVal($sformatf("mult_busy%0d", k), MdBusy, (k >= 2 && k <= 5));
      checkVal($sformatf("mult_done%0d", k), MdDone, (k == 6));
      checkVal($sformatf("mult_hilo%0d", k), HiLoWrite, (k == 6));
      checkVal($sformatf("mult_rdy%0d", k), InReady, (k >= 7));
      checkVal($sformatf("mult_outvalid%0d", k), OutValid, (k == 8));
      checkVal($sformatf("mult_code%0d", k), ALUControlBit, (k == 8) ? 4'h2 : 4'hF);
    end
    InValid = 1'b0;
    @(negedge clk);
    checkVal("after_add_valid", OutValid, 0);

    // div aborted by async reset mid-BUSY
    drive(1'b1, 4'h2, 6'h1A);
    checkVal("div_start", MdStart, 1);
    InValid = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("div_busy", MdBusy, 1);
    #2 rst_n = 1'b0;
    #1;
    checkVal("abort_busy", MdBusy, 0);
    checkVal("abort_done", MdDone, 0);
    checkVal("abort_code", ALUControlBit, 4'hF);
    checkVal("abort_rdy", InReady, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sawDone = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (MdDone || HiLoWrite || MdBusy) sawDone = 1'b1;
    end
    checkVal("abort_no_done", sawDone, 0);
    checkVal("abort_rdy_after", InReady, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
